// File: rtl/memarb_pkg.sv
// Shared definitions for the two-port memory bus arbiter: FSM encoding,
// port identifiers, bank-select codes, default bank map and error word.
package memarb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int OFS_W  = 10;

  localparam logic [ADDR_W-1:0] DEF_BASE0      = 16'd1000;
  localparam logic [ADDR_W-1:0] DEF_BASE1      = 16'd3048;
  localparam int                DEF_BANK_WORDS = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CAPT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam logic [1:0] SEL_NONE  = 2'b00;
  localparam logic [1:0] SEL_BANK0 = 2'b01;
  localparam logic [1:0] SEL_BANK1 = 2'b10;

  localparam logic [DATA_W-1:0] ERR_WORD = 32'hDEADBEEF;

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational word-address decoder: maps an address onto one of two banks
// and a bank offset; anything outside both windows (or 16'hFFFF) is unmapped.
module mem_addr_decode
  import memarb_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE0      = DEF_BASE0,
  parameter logic [ADDR_W-1:0] BASE1      = DEF_BASE1,
  parameter int                BANK_WORDS = DEF_BANK_WORDS
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [1:0]        sel,
  output logic [OFS_W-1:0]  offset,
  output logic              unmapped
);

  localparam int ADDR_XW = ADDR_W + 1;

  // Limits are one bit wider so a window running past 16'hFFFF never wraps to low addresses.
  localparam logic [ADDR_W:0] LIM0 = {1'b0, BASE0} + ADDR_XW'(BANK_WORDS);
  localparam logic [ADDR_W:0] LIM1 = {1'b0, BASE1} + ADDR_XW'(BANK_WORDS);

  logic [ADDR_W:0] addr_x;
  logic            in0;
  logic            in1;

  always_comb begin
    addr_x   = {1'b0, addr};
    in0      = (addr != '1) && (addr >= BASE0) && (addr_x < LIM0);
    in1      = (addr != '1) && (addr >= BASE1) && (addr_x < LIM1);
    sel      = SEL_NONE;
    offset   = '0;
    unmapped = 1'b1;
    if (in0) begin
      sel      = SEL_BANK0;
      offset   = OFS_W'(addr - BASE0);
      unmapped = 1'b0;
    end else if (in1) begin
      sel      = SEL_BANK1;
      offset   = OFS_W'(addr - BASE1);
      unmapped = 1'b0;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter with alternating tie-break priority and
// fully registered outputs. Define MEMARB_DECERR_EN to flag unmapped accesses.
module mem_bus_arbiter
  import memarb_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE0      = DEF_BASE0,
  parameter logic [ADDR_W-1:0] BASE1      = DEF_BASE1,
  parameter int                BANK_WORDS = DEF_BANK_WORDS
) (
  input  logic              iCLOCK,
  input  logic              iRESET,
  input  logic              iREQ_A,
  input  logic              iREQ_B,
  input  logic              iWE_A,
  input  logic              iWE_B,
  input  logic [ADDR_W-1:0] iADDR_A,
  input  logic [ADDR_W-1:0] iADDR_B,
  input  logic [DATA_W-1:0] iWDATA_A,
  input  logic [DATA_W-1:0] iWDATA_B,
  output logic              oACK_A,
  output logic              oACK_B,
  output logic [DATA_W-1:0] oRDATA_A,
  output logic [DATA_W-1:0] oRDATA_B,
  output logic              oERR_A,
  output logic              oERR_B,
  output logic [1:0]        oMEM_SEL,
  output logic              oMEM_WE,
  output logic [OFS_W-1:0]  oMEM_ADDR,
  output logic [DATA_W-1:0] oMEM_WDATA,
  input  logic [DATA_W-1:0] iMEM_RDATA
);

`ifdef MEMARB_DECERR_EN
  localparam logic [DATA_W-1:0] UNMAPPED_WORD = ERR_WORD;
`else
  localparam logic [DATA_W-1:0] UNMAPPED_WORD = '0;
`endif

  state_t state;
  state_t state_nx;

  logic              ptr;
  logic              any_req;
  logic              grant_b;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  logic [1:0]        dec_sel;
  logic [OFS_W-1:0]  dec_ofs;
  logic              dec_unmapped;

  logic              lat_port;
  logic              lat_we;
  logic              lat_unmapped;
  logic [DATA_W-1:0] cap_word;

  logic [1:0]        mem_sel,   mem_sel_d;
  logic              mem_we,    mem_we_d;
  logic [OFS_W-1:0]  mem_addr,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata, mem_wdata_d;
  logic              ack_a,     ack_a_d;
  logic              ack_b,     ack_b_d;
  logic [DATA_W-1:0] rdata_a,   rdata_a_d;
  logic [DATA_W-1:0] rdata_b,   rdata_b_d;

  // A simultaneous request goes to the port named by ptr; a lone request always wins.
  always_comb begin
    any_req   = iREQ_A | iREQ_B;
    grant_b   = iREQ_B & (~iREQ_A | (ptr == PORT_B));
    win_we    = grant_b ? iWE_B    : iWE_A;
    win_addr  = grant_b ? iADDR_B  : iADDR_A;
    win_wdata = grant_b ? iWDATA_B : iWDATA_A;
  end

  // Decodes the winning address as it is latched, so ISSUE outputs are ready on entry.
  mem_addr_decode #(
    .BASE0      (BASE0),
    .BASE1      (BASE1),
    .BANK_WORDS (BANK_WORDS)
  ) u_decode (
    .addr     (win_addr),
    .sel      (dec_sel),
    .offset   (dec_ofs),
    .unmapped (dec_unmapped)
  );

  assign cap_word = lat_unmapped ? UNMAPPED_WORD : iMEM_RDATA;

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (any_req) state_nx = ST_ISSUE;
      ST_ISSUE: state_nx = lat_we ? ST_ACK : ST_CAPT;
      ST_CAPT:  state_nx = ST_ACK;
      ST_ACK:   state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Next values of the output registers, so every output lines up with the state it belongs to.
  always_comb begin
    mem_sel_d   = SEL_NONE;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    ack_a_d     = 1'b0;
    ack_b_d     = 1'b0;
    rdata_a_d   = rdata_a;
    rdata_b_d   = rdata_b;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          mem_sel_d   = dec_sel;
          mem_we_d    = win_we & ~dec_unmapped;
          mem_addr_d  = dec_ofs;
          mem_wdata_d = win_wdata;
        end
      end
      ST_ISSUE: begin
        if (lat_we) begin
          ack_a_d = (lat_port == PORT_A);
          ack_b_d = (lat_port == PORT_B);
        end
      end
      ST_CAPT: begin
        ack_a_d = (lat_port == PORT_A);
        ack_b_d = (lat_port == PORT_B);
        if (lat_port == PORT_A) begin
          rdata_a_d = cap_word;
        end else begin
          rdata_b_d = cap_word;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      mem_sel   <= SEL_NONE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      rdata_a   <= '0;
      rdata_b   <= '0;
    end else begin
      mem_sel   <= mem_sel_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      ack_a     <= ack_a_d;
      ack_b     <= ack_b_d;
      rdata_a   <= rdata_a_d;
      rdata_b   <= rdata_b_d;
    end
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      ptr          <= PORT_A;
      lat_port     <= PORT_A;
      lat_we       <= 1'b0;
      lat_unmapped <= 1'b0;
    end else if ((state == ST_IDLE) && any_req) begin
      ptr          <= grant_b ? PORT_A : PORT_B;
      lat_port     <= grant_b;
      lat_we       <= win_we;
      lat_unmapped <= dec_unmapped;
    end
  end

`ifdef MEMARB_DECERR_EN
  logic err_a;
  logic err_b;

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      err_a <= 1'b0;
      err_b <= 1'b0;
    end else begin
      if (ack_a_d) err_a <= lat_unmapped;
      if (ack_b_d) err_b <= lat_unmapped;
    end
  end

  assign oERR_A = err_a;
  assign oERR_B = err_b;
`else
  assign oERR_A = 1'b0;
  assign oERR_B = 1'b0;
`endif

  assign oMEM_SEL   = mem_sel;
  assign oMEM_WE    = mem_we;
  assign oMEM_ADDR  = mem_addr;
  assign oMEM_WDATA = mem_wdata;
  assign oACK_A     = ack_a;
  assign oACK_B     = ack_b;
  assign oRDATA_A   = rdata_a;
  assign oRDATA_B   = rdata_b;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed transactions push expected bus
// strobes and acks into queues; a monitor pops and compares as the DUT produces them.
module tb_mem_bus_arbiter;

  logic        iCLOCK;
  logic        iRESET;
  logic        iREQ_A, iREQ_B;
  logic        iWE_A, iWE_B;
  logic [15:0] iADDR_A, iADDR_B;
  logic [31:0] iWDATA_A, iWDATA_B;
  logic        oACK_A, oACK_B;
  logic [31:0] oRDATA_A, oRDATA_B;
  logic        oERR_A, oERR_B;
  logic [1:0]  oMEM_SEL;
  logic        oMEM_WE;
  logic [9:0]  oMEM_ADDR;
  logic [31:0] oMEM_WDATA;
  logic [31:0] iMEM_RDATA;

  mem_bus_arbiter dut (
    .iCLOCK     (iCLOCK),
    .iRESET     (iRESET),
    .iREQ_A     (iREQ_A),
    .iREQ_B     (iREQ_B),
    .iWE_A      (iWE_A),
    .iWE_B      (iWE_B),
    .iADDR_A    (iADDR_A),
    .iADDR_B    (iADDR_B),
    .iWDATA_A   (iWDATA_A),
    .iWDATA_B   (iWDATA_B),
    .oACK_A     (oACK_A),
    .oACK_B     (oACK_B),
    .oRDATA_A   (oRDATA_A),
    .oRDATA_B   (oRDATA_B),
    .oERR_A     (oERR_A),
    .oERR_B     (oERR_B),
    .oMEM_SEL   (oMEM_SEL),
    .oMEM_WE    (oMEM_WE),
    .oMEM_ADDR  (oMEM_ADDR),
    .oMEM_WDATA (oMEM_WDATA),
    .iMEM_RDATA (iMEM_RDATA)
  );

`ifdef MEMARB_DECERR_EN
  localparam logic [31:0] UNM_WORD = 32'hDEADBEEF;
  localparam logic        UNM_ERR  = 1'b1;
`else
  localparam logic [31:0] UNM_WORD = 32'h0;
  localparam logic        UNM_ERR  = 1'b0;
`endif

  typedef struct {
    logic [1:0]  sel;
    logic        we;
    logic [9:0]  ofs;
    logic [31:0] wdata;
    int          at;
  } bus_exp_t;

  typedef struct {
    logic        port;
    logic        rd;
    logic [31:0] rdata;
    logic        err;
    int          at;
  } ack_exp_t;

  bus_exp_t    bus_q[$];
  ack_exp_t    ack_q[$];
  int          checks = 0;
  int          errors = 0;
  int          edges  = 0;
  logic [31:0] bank0[1024];
  logic [31:0] bank1[1024];
  logic [31:0] last_a = 0;
  logic [31:0] last_b = 0;

  initial begin
    iCLOCK = 1'b0;
    forever #5 iCLOCK = ~iCLOCK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  function automatic logic [31:0] init_val(input int bank, input int ofs);
    if (bank == 1 && ofs == 2) return 32'hCAFEF00D;
    return (bank == 0 ? 32'hA0000000 : 32'hB0000000) | 32'(ofs);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bdecode(input logic [15:0] a, output logic [1:0] sel, output logic [9:0] ofs);
    int ai;
    ai  = int'(a);
    sel = 2'b00;
    ofs = '0;
    if (ai >= 1000 && ai < 2024) begin
      sel = 2'b01;
      ofs = 10'(ai - 1000);
    end else if (ai >= 3048 && ai < 4072) begin
      sel = 2'b10;
      ofs = 10'(ai - 3048);
    end
  endtask

  // k is the rising edge that samples the request; -1 skips latency checks.
  task automatic expect_txn(input logic port, input logic we, input logic [15:0] addr,
                            input logic [31:0] wdata, input int k, input logic with_ack);
    logic [1:0] sel;
    logic [9:0] ofs;
    bus_exp_t   be;
    ack_exp_t   ae;
    bdecode(addr, sel, ofs);
    if (sel != 2'b00) begin
      be.sel = sel; be.we = we; be.ofs = ofs; be.wdata = wdata;
      be.at  = (k < 0) ? -1 : k + 1;
      bus_q.push_back(be);
    end
    if (with_ack) begin
      ae.port  = port;
      ae.rd    = ~we;
      ae.rdata = (sel == 2'b00) ? UNM_WORD : init_val(sel == 2'b01 ? 0 : 1, int'(ofs));
      ae.err   = (sel == 2'b00) ? UNM_ERR : 1'b0;
      ae.at    = (k < 0) ? -1 : (we ? k + 2 : k + 3);
      ack_q.push_back(ae);
    end
  endtask

  task automatic drive_req(input logic port, input logic we, input logic [15:0] addr,
                           input logic [31:0] wdata);
    if (port == 1'b0) begin
      iWE_A = we; iADDR_A = addr; iWDATA_A = wdata; iREQ_A = 1'b1;
    end else begin
      iWE_B = we; iADDR_B = addr; iWDATA_B = wdata; iREQ_B = 1'b1;
    end
  endtask

  task automatic wait_ack(input logic port, input string name);
    int n;
    n = 0;
    do begin
      @(negedge iCLOCK);
      n++;
    end while (!(port ? oACK_B : oACK_A) && n < 40);
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no ack after %0d cycles, required within 3", name, n);
    end
    if (port == 1'b0) iREQ_A = 1'b0; else iREQ_B = 1'b0;
  endtask

  task automatic run_txn(input logic port, input logic we, input logic [15:0] addr,
                         input logic [31:0] wdata, input string name);
    @(negedge iCLOCK);
    expect_txn(port, we, addr, wdata, edges + 1, 1'b1);
    drive_req(port, we, addr, wdata);
    wait_ack(port, name);
    @(negedge iCLOCK);
  endtask

  task automatic requester(input logic port, input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      drive_req(port, 1'b0, base + 16'(i), 32'h0);
      wait_ack(port, port ? "rr_b" : "rr_a");
      @(negedge iCLOCK);
    end
  endtask

  // Memory model: read data appears in the cycle after the select cycle.
  initial begin
    logic        rd_pend;
    logic [31:0] rd_word;
    for (int i = 0; i < 1024; i++) begin
      bank0[i] = init_val(0, i);
      bank1[i] = init_val(1, i);
    end
    rd_pend    = 1'b0;
    rd_word    = '0;
    iMEM_RDATA = 32'h0BAD0BAD;
    forever begin
      @(posedge iCLOCK);
      #2;
      iMEM_RDATA = rd_pend ? rd_word : 32'h0BAD0BAD;
      rd_pend    = 1'b0;
      if (oMEM_SEL != 2'b00 && !iRESET) begin
        if (oMEM_WE) begin
          if (oMEM_SEL[0]) bank0[oMEM_ADDR] = oMEM_WDATA;
          else             bank1[oMEM_ADDR] = oMEM_WDATA;
        end else begin
          rd_pend = 1'b1;
          rd_word = oMEM_SEL[0] ? bank0[oMEM_ADDR] : bank1[oMEM_ADDR];
        end
      end
    end
  end

  // Monitor: cycle n is the clock period ending at rising edge n.
  initial begin
    bus_exp_t be;
    ack_exp_t ae;
    forever begin
      @(posedge iCLOCK);
      edges++;
      #1;
      if (iRESET) begin
        last_a = '0;
        last_b = '0;
      end else begin
        if (oMEM_SEL != 2'b00 || oMEM_WE) begin
          if (bus_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL bus_unexpected: sel=%b we=%b addr=%0d in cycle %0d, required idle bus",
                     oMEM_SEL, oMEM_WE, oMEM_ADDR, edges + 1);
          end else begin
            be = bus_q.pop_front();
            chk("mem_sel", 32'(oMEM_SEL), 32'(be.sel));
            chk("mem_we", 32'(oMEM_WE), 32'(be.we));
            chk("mem_addr", 32'(oMEM_ADDR), 32'(be.ofs));
            if (be.we) chk("mem_wdata", oMEM_WDATA, be.wdata);
            if (be.at >= 0) chk("bus_cycle", 32'(edges + 1), 32'(be.at));
          end
        end
        if (oACK_A || oACK_B) begin
          chk("ack_overlap", 32'(oACK_A & oACK_B), 32'd0);
          if (ack_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ack_unexpected: ack_a=%b ack_b=%b in cycle %0d, required none",
                     oACK_A, oACK_B, edges + 1);
          end else begin
            ae = ack_q.pop_front();
            chk("ack_port", 32'(oACK_B), 32'(ae.port));
            if (ae.at >= 0) chk("ack_cycle", 32'(edges + 1), 32'(ae.at));
            if (ae.port) begin
              if (ae.rd) last_b = ae.rdata;
              chk("rdata_b", oRDATA_B, last_b);
              chk("rdata_a_hold", oRDATA_A, last_a);
              chk("err_b", 32'(oERR_B), 32'(ae.err));
            end else begin
              if (ae.rd) last_a = ae.rdata;
              chk("rdata_a", oRDATA_A, last_a);
              chk("rdata_b_hold", oRDATA_B, last_b);
              chk("err_a", 32'(oERR_A), 32'(ae.err));
            end
          end
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack_a"}, 32'(oACK_A), 32'd0);
    chk({tag, "_ack_b"}, 32'(oACK_B), 32'd0);
    chk({tag, "_rdata_a"}, oRDATA_A, 32'd0);
    chk({tag, "_rdata_b"}, oRDATA_B, 32'd0);
    chk({tag, "_err"}, 32'({oERR_A, oERR_B}), 32'd0);
    chk({tag, "_mem_sel"}, 32'(oMEM_SEL), 32'd0);
    chk({tag, "_mem_we"}, 32'(oMEM_WE), 32'd0);
    chk({tag, "_mem_addr"}, 32'(oMEM_ADDR), 32'd0);
    chk({tag, "_mem_wdata"}, oMEM_WDATA, 32'd0);
  endtask

  initial begin
    iRESET = 1'b1;
    iREQ_A = 1'b0; iREQ_B = 1'b0;
    iWE_A = 1'b0; iWE_B = 1'b0;
    iADDR_A = '0; iADDR_B = '0;
    iWDATA_A = '0; iWDATA_B = '0;
    repeat (3) @(negedge iCLOCK);
    chk_all_zero("reset");
    iRESET = 1'b0;

    run_txn(1'b0, 1'b1, 16'd1000, 32'h12345678, "a_wr_1000");
    run_txn(1'b1, 1'b0, 16'd3050, 32'h0, "b_rd_3050");
    run_txn(1'b0, 1'b0, 16'd2023, 32'h0, "a_rd_2023");
    run_txn(1'b0, 1'b0, 16'd3047, 32'h0, "a_rd_3047");
    run_txn(1'b0, 1'b0, 16'd2024, 32'h0, "a_rd_2024");
    run_txn(1'b1, 1'b1, 16'd4071, 32'h0F0F1234, "b_wr_4071");
    run_txn(1'b1, 1'b0, 16'd4072, 32'h0, "b_rd_4072");
    run_txn(1'b0, 1'b1, 16'hFFFF, 32'h55AA55AA, "a_wr_ffff");
    run_txn(1'b0, 1'b0, 16'd999, 32'h0, "a_rd_999");

    // Abort a write by asserting reset during its bus cycle.
    @(negedge iCLOCK);
    expect_txn(1'b0, 1'b1, 16'd3048, 32'h77778888, edges + 1, 1'b0);
    drive_req(1'b0, 1'b1, 16'd3048, 32'h77778888);
    @(posedge iCLOCK);
    #3;
    iRESET = 1'b1;
    #1;
    chk_all_zero("abort");
    @(negedge iCLOCK);
    iREQ_A = 1'b0;
    @(negedge iCLOCK);
    iRESET = 1'b0;
    repeat (5) @(negedge iCLOCK);

    // Both requesters held from reset: grants must alternate A,B,A,B.
    expect_txn(1'b0, 1'b0, 16'd1001, 32'h0, -1, 1'b1);
    expect_txn(1'b1, 1'b0, 16'd3049, 32'h0, -1, 1'b1);
    expect_txn(1'b0, 1'b0, 16'd1002, 32'h0, -1, 1'b1);
    expect_txn(1'b1, 1'b0, 16'd3050, 32'h0, -1, 1'b1);
    fork
      requester(1'b0, 2, 16'd1001);
      requester(1'b1, 2, 16'd3049);
    join

    repeat (6) @(negedge iCLOCK);
    chk("ack_queue_drained", 32'(ack_q.size()), 32'd0);
    chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
